// File: rtl/kara_recomb_seq_pkg.sv
// Shared types and constants for the Karatsuba recombination stage.
package kara_pkg;

  localparam int W         = 32;
  localparam int Z1W       = 34;
  localparam int PW        = 64;
  localparam int MID_SHIFT = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SUB0 = 3'd1,
    SUB1 = 3'd2,
    LO   = 3'd3,
    HI   = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/kara_recomb_seq_if.sv
// Operand/product handshake bundle for kara_recomb_seq.
// err is present only when KARA_CHECK_EN is defined.
interface kara_recomb_seq_if;

  logic                       in_valid;
  logic                       in_ready;
  logic [kara_pkg::W-1:0]     z0;
  logic [kara_pkg::Z1W-1:0]   z1;
  logic [kara_pkg::W-1:0]     z2;
  logic                       out_valid;
  logic                       out_ready;
  logic [kara_pkg::PW-1:0]    p;
`ifdef KARA_CHECK_EN
  logic                       err;
`endif

  modport master (
    output in_valid, z0, z1, z2, out_ready,
    input  in_ready, out_valid, p
`ifdef KARA_CHECK_EN
    , input err
`endif
  );

  modport slave (
    input  in_valid, z0, z1, z2, out_ready,
    output in_ready, out_valid, p
`ifdef KARA_CHECK_EN
    , output err
`endif
  );

endinterface

// File: rtl/kara_recomb_seq_cla32.sv
// 32-bit adder built from 4-bit carry-lookahead groups with a lookahead
// chain across groups; shared by every pass of the recombination stage.
module scb_cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] gen;
  logic [31:0] prop;
  logic [31:0] cbit;
  logic [7:0]  gg;
  logic [7:0]  pg;
  logic [8:0]  gc;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    gg = '0;
    pg = '0;
    gc = '0;
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      gg[k] = gen[4*k+3]
            | (prop[4*k+3] & gen[4*k+2])
            | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
            | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
      pg[k] = prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & prop[4*k];
      gc[k+1] = gg[k] | (pg[k] & gc[k]);
    end
  end

  // Bit carries only ripple inside a 4-bit group; group entries come from gc.
  always_comb begin
    cbit = '0;
    for (int i = 0; i < 32; i++) begin
      if ((i % 4) == 0)
        cbit[i] = gc[i/4];
      else
        cbit[i] = gen[i-1] | (prop[i-1] & cbit[i-1]);
    end
  end

  assign sum  = prop ^ cbit;
  assign cout = gc[8];

endmodule

// File: rtl/kara_recomb_seq.sv
// Karatsuba recombination P = (z2<<32) + ((z1-z2-z0)<<16) + z0 using one
// shared 32-bit adder over four passes. KARA_CHECK_EN adds the err output.
module kara_recomb_seq
  import kara_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  kara_recomb_seq_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready=1
  // SUB0  | t = z1 - z0 (34 bit)
  // SUB1  | m = t - z2 (34 bit)
  // LO    | P[31:0]  = z0 + (m[15:0] << 16), carry c0
  // HI    | P[63:32] = z2 + m[33:16] + c0
  // DONE  | p valid, wait for out_ready

  state_t             state_q, state_d;

  logic [W-1:0]       z0_q;
  logic [Z1W-1:0]     z1_q;
  logic [W-1:0]       z2_q;
  logic [Z1W-1:0]     tm_q;
  logic [W-1:0]       lo_q;
  logic               c0_q;
  logic [PW-1:0]      p_q;

  logic [W-1:0]       add_a, add_b, add_sum;
  logic               add_cin, add_co;
  logic [Z1W-W-1:0]   hi_src, hi_sum;
  logic               accept;

`ifdef KARA_CHECK_EN
  logic               hi_co;
  logic               b0_q;
  logic               err_q;
`endif

  assign accept = bus.in_valid && (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Adder operands depend only on the registered state and registers.
  always_comb begin
    state_d = state_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    hi_src  = '0;
    case (state_q)
      IDLE: begin
        if (accept)
          state_d = SUB0;
      end
      SUB0: begin
        add_a   = z1_q[W-1:0];
        add_b   = ~z0_q;
        add_cin = 1'b1;
        hi_src  = z1_q[Z1W-1:W];
        state_d = SUB1;
      end
      SUB1: begin
        add_a   = tm_q[W-1:0];
        add_b   = ~z2_q;
        add_cin = 1'b1;
        hi_src  = tm_q[Z1W-1:W];
        state_d = LO;
      end
      LO: begin
        add_a   = z0_q;
        add_b   = {tm_q[MID_SHIFT-1:0], {MID_SHIFT{1'b0}}};
        state_d = HI;
      end
      HI: begin
        add_a   = z2_q;
        add_b   = {{(W-Z1W+MID_SHIFT){1'b0}}, tm_q[Z1W-1:MID_SHIFT]};
        add_cin = c0_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  scb_cla32 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_co)
  );

  // Upper two bits of the 34-bit subtraction: hi_src + ~0 + carry.
`ifdef KARA_CHECK_EN
  assign {hi_co, hi_sum} = {1'b0, hi_src} + 3'b011 + {2'b00, add_co};
`else
  assign hi_sum = hi_src + 2'b11 + {1'b0, add_co};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z0_q  <= '0;
      z1_q  <= '0;
      z2_q  <= '0;
      tm_q  <= '0;
      lo_q  <= '0;
      c0_q  <= 1'b0;
      p_q   <= '0;
`ifdef KARA_CHECK_EN
      b0_q  <= 1'b0;
      err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            z0_q  <= bus.z0;
            z1_q  <= bus.z1;
            z2_q  <= bus.z2;
`ifdef KARA_CHECK_EN
            err_q <= 1'b0;
`endif
          end
        end
        SUB0: begin
          tm_q <= {hi_sum, add_sum};
`ifdef KARA_CHECK_EN
          b0_q <= ~hi_co;
`endif
        end
        SUB1: begin
          tm_q  <= {hi_sum, add_sum};
`ifdef KARA_CHECK_EN
          // Either pass borrowing means z1 < z0 + z2; both cannot borrow.
          err_q <= b0_q | ~hi_co;
`endif
        end
        LO: begin
          lo_q <= add_sum;
          c0_q <= add_co;
        end
        HI: begin
          p_q <= {add_sum, lo_q};
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.p         = p_q;
`ifdef KARA_CHECK_EN
  assign bus.err       = err_q;
`endif

endmodule

// File: tb/tb_kara_recomb_seq.sv
// Directed bench for kara_recomb_seq: hand-computed products, latency,
// backpressure and mid-operation reset; err checks when KARA_CHECK_EN is set.
module tb_kara_recomb_seq;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  kara_recomb_seq_if bus ();

  kara_recomb_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a0, input logic [33:0] a1,
                         input logic [31:0] a2, input logic [63:0] ep,
                         input int hold, input bit early_ready);
    int cnt;
`ifdef KARA_CHECK_EN
    logic exp_err;
    exp_err = ({1'b0, a1} < ({3'b000, a0} + {3'b000, a2}));
`endif
    @(negedge clk);
    check({tag, " idle_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.z0        = a0;
    bus.z1        = a1;
    bus.z2        = a2;
    bus.in_valid  = 1'b1;
    bus.out_ready = early_ready;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.z0       = ~a0;
    bus.z1       = ~a1;
    bus.z2       = ~a2;
    check({tag, " busy_in_ready"}, 64'(bus.in_ready), 64'd0);
`ifdef KARA_CHECK_EN
    check({tag, " err_cleared"}, 64'(bus.err), 64'd0);
`endif
    cnt = 0;
    while (!bus.out_valid && cnt < 12) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, " latency"}, 64'(cnt), 64'd4);
    check({tag, " p"}, bus.p, ep);
`ifdef KARA_CHECK_EN
    check({tag, " err"}, 64'(bus.err), 64'(exp_err));
`endif
    for (int i = 0; i < hold; i++) begin
      check({tag, " hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, " hold_p"}, bus.p, ep);
      check({tag, " hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b1;
      bus.z0       = 32'h1234_5678;
      bus.z1       = 34'h0_0000_0001;
      bus.z2       = 32'h0000_0003;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, " release_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, " release_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, " release_p"}, bus.p, ep);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.z0        = '0;
    bus.z1        = '0;
    bus.z2        = '0;
    #12;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset p", bus.p, 64'd0);
`ifdef KARA_CHECK_EN
    check("reset err", 64'(bus.err), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_vec("v_small", 32'h0000_000F, 34'h0_0000_000F, 32'h0000_0000,
            64'h0000_0000_0000_000F, 0, 1'b0);
    // a=b=0x00010000; out_ready held high from the start must not shortcut anything
    run_vec("v_m0", 32'h0000_0000, 34'h0_0000_0001, 32'h0000_0001,
            64'h0000_0001_0000_0000, 0, 1'b1);
    // a=b=0xFFFFFFFF with three cycles of backpressure
    run_vec("v_max", 32'hFFFE_0001, 34'h3_FFF8_0004, 32'hFFFE_0001,
            64'hFFFF_FFFE_0000_0001, 3, 1'b0);
    // a=0x00020003, b=0x00040005
    run_vec("v_mix", 32'h0000_000F, 34'h0_0000_002D, 32'h0000_0008,
            64'h0000_0008_0016_000F, 1, 1'b0);
    // a=b=0x0001FFFF, low pass carries into the high pass
    run_vec("v_c0", 32'hFFFE_0001, 34'h1_0000_0000, 32'h0000_0001,
            64'h0000_0003_FFFC_0001, 0, 1'b0);

    // Reset while the LO pass is in flight
    @(negedge clk);
    bus.z0       = 32'hFFFE_0001;
    bus.z1       = 34'h3_FFF8_0004;
    bus.z2       = 32'hFFFE_0001;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst pre in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("midrst out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst p", bus.p, 64'd0);
    check("midrst in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst no_output", 64'(bus.out_valid), 64'd0);
    check("midrst still_idle", 64'(bus.in_ready), 64'd1);
    run_vec("v_after_rst", 32'h0000_000F, 34'h0_0000_002D, 32'h0000_0008,
            64'h0000_0008_0016_000F, 0, 1'b0);

`ifdef KARA_CHECK_EN
    run_vec("v_err", 32'h0000_0005, 34'h0_0000_0000, 32'h0000_0000,
            64'h0003_FFFF_FFFB_0005, 0, 1'b0);
    check("err held in idle", 64'(bus.err), 64'd1);
    run_vec("v_err_clear", 32'h0000_0000, 34'h0_0000_0001, 32'h0000_0001,
            64'h0000_0001_0000_0000, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
